// File: rtl/if_id_pipe_skid_if.sv
// Handshake and decode-field bundle between instruction fetch, the IF/ID skid stage and decode.
// master = fetch/decode side, slave = the pipeline stage.
interface if_id_pipe_skid_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16
) ();
  logic                   if_valid;
  logic                   if_ready;
  logic [DATA_W-1:0]      DO;
  logic [PC_W-1:0]        PC_4;
  logic                   flush;
  logic                   id_ready;
  logic                   id_valid;
  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic [25:0]            JUMP_ADDR;
  logic [4:0]             rs;
  logic [4:0]             rt;
  logic [4:0]             rd;
  logic [15:0]            imm;
  logic [PC_W-1:0]        pc_4;
  logic [PC_W+DATA_W-1:0] aux;
  logic [1:0]             occupancy;
  logic [CNT_W-1:0]       stall_cnt;

  modport master (
    output if_valid, DO, PC_4, flush, id_ready,
    input  if_ready, id_valid, opcode, funct, JUMP_ADDR, rs, rt, rd, imm,
           pc_4, aux, occupancy, stall_cnt
  );

  modport slave (
    input  if_valid, DO, PC_4, flush, id_ready,
    output if_ready, id_valid, opcode, funct, JUMP_ADDR, rs, rt, rd, imm,
           pc_4, aux, occupancy, stall_cnt
  );
endinterface

// File: rtl/if_id_pipe_skid.sv
// IF/ID pipeline stage: valid/ready handshake with a main register plus one skid entry,
// synchronous flush, NOP output while empty and a saturating decode-stall counter.
module if_id_pipe_skid #(
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       PC_W   = 32,
  parameter logic [DATA_W-1:0] NOP    = '0,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic             reloj,
  input  logic             resetIF_n,
  if_id_pipe_skid_if.slave bus
);

  // Encoding chosen so bit 0 is the main-valid flag and bit 1 the skid-valid flag.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_instr_q, m_instr_d;
  logic [PC_W-1:0]   m_pc_q, m_pc_d;
  logic [DATA_W-1:0] s_instr_q, s_instr_d;
  logic [PC_W-1:0]   s_pc_q, s_pc_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [1:0]        occ_q, occ_d;

  logic              v_m, v_s, acc, pop;
  logic [DATA_W-1:0] head;
  logic [PC_W-1:0]   head_pc;

  assign v_m = (state_q != EMPTY);
  assign v_s = (state_q == TWO);
  assign acc = bus.if_valid & ~v_s;
  assign pop = v_m & bus.id_ready;

  always_comb begin
    state_d   = state_q;
    m_instr_d = m_instr_q;
    m_pc_d    = m_pc_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          m_instr_d = bus.DO;
          m_pc_d    = bus.PC_4;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (acc && pop) begin
          m_instr_d = bus.DO;
          m_pc_d    = bus.PC_4;
        end else if (acc) begin
          s_instr_d = bus.DO;
          s_pc_d    = bus.PC_4;
          state_d   = TWO;
        end else if (pop) begin
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          m_instr_d = s_instr_q;
          m_pc_d    = s_pc_q;
          s_instr_d = '0;
          s_pc_d    = '0;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides every transition; payloads may still load, they are never shown.
    if (bus.flush) state_d = EMPTY;
  end

  always_comb begin
    stall_d = stall_q;
    if (v_m && !bus.id_ready && !bus.flush && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  always_comb begin
    occ_d = 2'd0;
    unique case (state_d)
      EMPTY:   occ_d = 2'd0;
      ONE:     occ_d = 2'd1;
      TWO:     occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge reloj or negedge resetIF_n) begin
    if (!resetIF_n) begin
      state_q   <= EMPTY;
      m_instr_q <= '0;
      m_pc_q    <= '0;
      s_instr_q <= '0;
      s_pc_q    <= '0;
      stall_q   <= '0;
      occ_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      m_instr_q <= m_instr_d;
      m_pc_q    <= m_pc_d;
      s_instr_q <= s_instr_d;
      s_pc_q    <= s_pc_d;
      stall_q   <= stall_d;
      occ_q     <= occ_d;
    end
  end

  assign head    = v_m ? m_instr_q : NOP;
  assign head_pc = v_m ? m_pc_q : '0;

  assign bus.if_ready  = ~v_s;
  assign bus.id_valid  = v_m;
  assign bus.opcode    = head[31:26];
  assign bus.funct     = head[5:0];
  assign bus.JUMP_ADDR = head[25:0];
  assign bus.rs        = head[25:21];
  assign bus.rt        = head[20:16];
  assign bus.rd        = head[15:11];
  assign bus.imm       = head[15:0];
  assign bus.pc_4      = head_pc;
  assign bus.aux       = {head_pc, head};
  assign bus.occupancy = occ_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_if_id_pipe_skid.sv
// Bench for if_id_pipe_skid: directed scenarios then random traffic, checked against a
// 2-deep queue model of the stage.
module tb_if_id_pipe_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 4;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  if_id_pipe_skid_if #(.DATA_W(DW), .PC_W(PW), .CNT_W(CW)) bus ();

  if_id_pipe_skid #(.DATA_W(DW), .PC_W(PW), .NOP(32'h0), .CNT_W(CW)) dut (
    .reloj    (clk),
    .resetIF_n(rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [DW-1:0] instr;
  } beat_t;

  beat_t       q[$];
  int unsigned cnt_m = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0]   hi;
    logic [PW-1:0] hp;
    beat_t         b;
    hi = 32'h0;
    hp = '0;
    if (q.size() > 0) begin
      b  = q[0];
      hi = b.instr;
      hp = b.pc;
    end
    chk({tag, ".id_valid"},  64'(bus.id_valid),  64'(q.size() > 0));
    chk({tag, ".if_ready"},  64'(bus.if_ready),  64'(q.size() < 2));
    chk({tag, ".occupancy"}, 64'(bus.occupancy), 64'(q.size()));
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(cnt_m));
    chk({tag, ".opcode"},    64'(bus.opcode),    64'(hi[31:26]));
    chk({tag, ".funct"},     64'(bus.funct),     64'(hi[5:0]));
    chk({tag, ".jump"},      64'(bus.JUMP_ADDR), 64'(hi[25:0]));
    chk({tag, ".rs"},        64'(bus.rs),        64'(hi[25:21]));
    chk({tag, ".rt"},        64'(bus.rt),        64'(hi[20:16]));
    chk({tag, ".rd"},        64'(bus.rd),        64'(hi[15:11]));
    chk({tag, ".imm"},       64'(bus.imm),       64'(hi[15:0]));
    chk({tag, ".pc_4"},      64'(bus.pc_4),      64'(hp));
    chk({tag, ".aux"},       64'(bus.aux),       64'({hp, hi}));
  endtask

  task automatic model_edge(input logic iv, input logic [31:0] d, input logic [PW-1:0] p,
                            input logic fl, input logic idr);
    logic acc, pop;
    acc = iv && (q.size() < 2);
    pop = (q.size() > 0) && idr;
    if ((q.size() > 0) && !idr && !fl && (cnt_m < 15)) cnt_m++;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{pc: p, instr: d});
    end
  endtask

  // Called at posedge+1: drive, check pre-edge outputs, advance one edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic [PW-1:0] p,
                      input logic fl, input logic idr, input string tag);
    bus.if_valid = iv;
    bus.DO       = d;
    bus.PC_4     = p;
    bus.flush    = fl;
    bus.id_ready = idr;
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge(iv, d, p, fl, idr);
    #1;
  endtask

  initial begin
    bus.if_valid = 1'b0;
    bus.DO       = '0;
    bus.PC_4     = '0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b0;

    // Reset state, and inputs ignored while reset is held
    #1 rst_n = 1'b0;
    #1 check_all("reset");
    bus.if_valid = 1'b1;
    bus.DO       = 32'hDEADBEEF;
    @(posedge clk); #1;
    check_all("reset_hold");
    bus.if_valid = 1'b0;
    rst_n = 1'b1;

    // Stream
    step(1'b1, 32'h8C220004, 4'h4, 1'b0, 1'b1, "t1_in");
    chk("t1_id_valid", 64'(bus.id_valid), 64'd1);
    chk("t1_opcode",   64'(bus.opcode),   64'h23);
    chk("t1_rs",       64'(bus.rs),       64'd1);
    chk("t1_rt",       64'(bus.rt),       64'd2);
    chk("t1_imm",      64'(bus.imm),      64'h0004);
    chk("t1_pc_4",     64'(bus.pc_4),     64'd4);
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'h20000000 + 32'(i), 4'(i + 5), 1'b0, 1'b1, "t1_stream");
    chk("t1_occ", 64'(bus.occupancy), 64'd1);
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, "t1_drain");

    // Back-pressure
    step(1'b1, 32'h20010011, 4'h1, 1'b0, 1'b0, "t2_a");
    step(1'b1, 32'h00431820, 4'h2, 1'b0, 1'b0, "t2_b");
    step(1'b1, 32'hAC220008, 4'h3, 1'b0, 1'b0, "t2_c_held");
    chk("t2_occ2",     64'(bus.occupancy), 64'd2);
    chk("t2_if_ready", 64'(bus.if_ready),  64'd0);
    chk("t2_head_a",   64'(bus.opcode),    64'h08);
    step(1'b1, 32'hAC220008, 4'h3, 1'b0, 1'b1, "t2_rel1");
    chk("t2_head_b", 64'(bus.pc_4), 64'd2);
    step(1'b1, 32'hAC220008, 4'h3, 1'b0, 1'b1, "t2_rel2");
    chk("t2_head_c", 64'(bus.pc_4), 64'd3);
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, "t2_rel3");
    chk("t2_empty", 64'(bus.id_valid), 64'd0);

    // Flush in TWO with a beat offered the same cycle
    step(1'b1, 32'h3C0A1234, 4'h5, 1'b0, 1'b0, "t3_d");
    step(1'b1, 32'h354A5678, 4'h6, 1'b0, 1'b0, "t3_e");
    step(1'b1, 32'h8D4B0000, 4'h7, 1'b1, 1'b0, "t3_flush");
    chk("t3_id_valid", 64'(bus.id_valid),  64'd0);
    chk("t3_occ",      64'(bus.occupancy), 64'd0);
    chk("t3_opcode",   64'(bus.opcode),    64'd0);
    chk("t3_if_ready", 64'(bus.if_ready),  64'd1);
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, "t3_after");
    chk("t3_no_ghost", 64'(bus.id_valid), 64'd0);

    // Asynchronous reset between edges while in TWO
    step(1'b1, 32'h11111111, 4'h1, 1'b0, 1'b0, "t4_a");
    step(1'b1, 32'h22222222, 4'h2, 1'b0, 1'b0, "t4_b");
    chk("t4_two", 64'(bus.occupancy), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    cnt_m = 0;
    check_all("t4_async");
    bus.if_valid = 1'b1;
    bus.DO       = 32'h33333333;
    @(posedge clk); #1;
    check_all("t4_hold");
    bus.if_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h8C440010, 4'h9, 1'b0, 1'b0, "t4_first");
    chk("t4_first_valid", 64'(bus.id_valid), 64'd1);
    chk("t4_first_pc",    64'(bus.pc_4),     64'd9);

    // Stall counter: flush cycle does not count, then saturation
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, "t5_flush");
    chk("t5_no_count", 64'(bus.stall_cnt), 64'd0);
    step(1'b1, 32'h8C550020, 4'hB, 1'b0, 1'b0, "t5_load");
    for (int i = 0; i < 20; i++)
      step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, "t5_stall");
    chk("t5_sat", 64'(bus.stall_cnt), 64'hF);
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, "t5_stay");
    chk("t5_stays", 64'(bus.stall_cnt), 64'hF);

    // Narrow PC: aux = {PC_4[3:0], DO}
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, "t6_drain");
    step(1'b1, 32'h08000010, 4'hA, 1'b0, 1'b1, "t6_j");
    chk("t6_jump",   64'(bus.JUMP_ADDR), 64'h0000010);
    chk("t6_opcode", 64'(bus.opcode),    64'h02);
    chk("t6_aux",    64'(bus.aux),       64'hA08000010);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, "rand");
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
